// File: rtl/band_scale_sched.sv
`default_nettype none
// ============================================================================
//  Module      : band_scale_sched
//  Description : Time-multiplexed band-gain scheduler. One shared squared-pot
//                multiplier scales every band, results are accumulated and
//                emitted as one saturated mixed sample per strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module band_scale_sched #(
    parameter int NUM_BANDS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_smpl_vld,
    input  logic [12*NUM_BANDS-1:0]  i_pots,
    input  logic [16*NUM_BANDS-1:0]  i_bands,
    output logic [15:0]              o_mix_out,
    output logic                     o_mix_vld,
    output logic                     o_busy,
    output logic                     o_overrun
);

    localparam int             IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ   = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [11:0]            r_pot  [NUM_BANDS];
    logic signed [15:0]     r_band [NUM_BANDS];
    logic [IDX_W-1:0]       r_idx;
    logic [11:0]            r_sq;
    logic signed [18:0]     r_acc;
    logic [15:0]            r_mix_out;
    logic                   r_mix_vld;
    logic                   r_overrun;

    logic [11:0]            w_pot;
    logic signed [15:0]     w_band;
    logic [11:0]            w_sq;
    logic signed [28:0]     w_sq_s;
    logic signed [28:0]     w_band_s;
    logic signed [28:0]     w_prod;
    logic                   w_band_ovf;
    logic signed [15:0]     w_bres;
    logic                   w_mix_ovf;
    logic [15:0]            w_sat_mix;

    // Shared gain path: gain = top 12 bits of pot^2, always non-negative
    assign w_pot      = r_pot[r_idx];
    assign w_band     = r_band[r_idx];
    assign w_sq       = 12'(({12'd0, w_pot} * {12'd0, w_pot}) >> 12);
    assign w_sq_s     = {17'd0, r_sq};
    assign w_band_s   = {{13{w_band[15]}}, w_band};
    assign w_prod     = w_sq_s * w_band_s;
    assign w_band_ovf = (w_prod[28:25] != 4'b0000) && (w_prod[28:25] != 4'b1111);
    assign w_bres     = w_band_ovf ? (w_prod[28] ? 16'sh8000 : 16'sh7FFF)
                                   : 16'(w_prod >> 10);

    assign w_mix_ovf  = (r_acc[18:15] != 4'b0000) && (r_acc[18:15] != 4'b1111);
    assign w_sat_mix  = w_mix_ovf ? (r_acc[18] ? 16'h8000 : 16'h7FFF) : r_acc[15:0];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_smpl_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SQ;
                end
            end
            S_SQ:   w_state_nxt = S_MUL;
            S_MUL:  w_state_nxt = (r_idx == C_LAST) ? S_DONE : S_SQ;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_pot[b]  <= '0;
                r_band[b] <= '0;
            end
            r_idx     <= '0;
            r_sq      <= '0;
            r_acc     <= '0;
            r_mix_out <= '0;
            r_mix_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_mix_vld <= 1'b0;
            // Strobes arriving mid-sequence are dropped, only flagged
            r_overrun <= i_smpl_vld && (r_state != S_IDLE);
            if (w_accept) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    r_pot[b]  <= i_pots[12*b +: 12];
                    r_band[b] <= i_bands[16*b +: 16];
                end
                r_acc <= '0;
                r_idx <= '0;
            end
            case (r_state)
                S_SQ: r_sq <= w_sq;
                S_MUL: begin
                    r_acc <= r_acc + {{3{w_bres[15]}}, w_bres};
                    if (r_idx != C_LAST) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_mix_out <= w_sat_mix;
                    r_mix_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_mix_out = r_mix_out;
    assign o_mix_vld = r_mix_vld;
    assign o_busy    = (r_state != S_IDLE);
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_band_scale_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_band_scale_sched
//  Description : Self-checking bench for band_scale_sched against an
//                arithmetic reference model of the band mix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_band_scale_sched;

    localparam int NB  = 5;
    localparam int LAT = 2 * NB + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              smpl_vld;
    logic [12*NB-1:0]  pots;
    logic [16*NB-1:0]  bands;
    logic [15:0]       mix_out;
    logic              mix_vld;
    logic              busy;
    logic              overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0]        pot_a  [NB];
    logic signed [15:0] band_a [NB];

    always #5 clk = ~clk;

    band_scale_sched #(.NUM_BANDS(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_smpl_vld (smpl_vld),
        .i_pots     (pots),
        .i_bands    (bands),
        .o_mix_out  (mix_out),
        .o_mix_vld  (mix_vld),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: gain = floor(pot^2/4096), band term = clamp(floor(gain*x/1024)),
    // output = clamp(sum of band terms) to the signed 16-bit range.
    function automatic logic [15:0] model();
        int acc;
        acc = 0;
        for (int b = 0; b < NB; b++) begin
            int g;
            int p;
            int r;
            g = (int'(pot_a[b]) * int'(pot_a[b])) / 4096;
            p = g * int'(band_a[b]);
            r = p >>> 10;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            acc += r;
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic set_all(input logic [11:0] p, input logic [15:0] v);
        for (int b = 0; b < NB; b++) begin
            pot_a[b]  = p;
            band_a[b] = v;
        end
    endtask

    task automatic rand_arrays();
        for (int b = 0; b < NB; b++) begin
            pot_a[b]  = 12'($urandom);
            band_a[b] = 16'($urandom);
        end
    endtask

    task automatic scramble_inputs();
        for (int b = 0; b < NB; b++) begin
            pots[12*b +: 12]  = 12'($urandom);
            bands[16*b +: 16] = 16'($urandom);
        end
    endtask

    // Called just after a rising edge; leaves the bench just after the capture edge
    task automatic capture();
        for (int b = 0; b < NB; b++) begin
            pots[12*b +: 12]  = pot_a[b];
            bands[16*b +: 16] = band_a[b];
        end
        smpl_vld = 1'b1;
        @(posedge clk);
        #1;
        smpl_vld = 1'b0;
        scramble_inputs();
        chk("busy_after_capture", {31'd0, busy}, 32'd1);
    endtask

    // inj: edge index (after capture) on which a stray strobe is sampled; 0 = none
    task automatic wait_result(input string tag, input logic [15:0] exp, input int inj);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        while (!got && n < LAT + 5) begin
            n++;
            if (n == inj) begin
                smpl_vld = 1'b1;
                scramble_inputs();
            end
            @(posedge clk);
            #1;
            smpl_vld = 1'b0;
            chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, (n == inj)});
            if (mix_vld) begin
                got = 1'b1;
            end else begin
                chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            end
        end
        chk({tag, "_latency"}, got ? n : -1, LAT);
        chk({tag, "_mix_out"}, {16'd0, mix_out}, {16'd0, exp});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] exp);
        capture();
        wait_result(tag, exp, 0);
    endtask

    initial begin
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] held;
        bit          stray;

        rst_n    = 1'b0;
        smpl_vld = 1'b0;
        pots     = '0;
        bands    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mix_out", {16'd0, mix_out}, 32'd0);
        chk("rst_mix_vld", {31'd0, mix_vld}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single band, unity-ish gain
        set_all(12'h000, 16'h0000);
        pot_a[0] = 12'hFFF; band_a[0] = 16'sh1000;
        directed("single", 16'h3FF8);

        // Zero gain kills loud input
        set_all(12'h000, 16'h7FFF);
        directed("zero_gain", 16'h0000);

        // Half pot -> gain 0x400; -4096 * 1024 / 1024
        set_all(12'h800, 16'h0000);
        band_a[2] = -16'sd4096;
        directed("half_pot", 16'hF000);

        // Per-band saturation, both polarities, and cancellation
        set_all(12'h000, 16'h0000);
        pot_a[0] = 12'hFFF; band_a[0] = 16'sh7FFF;
        directed("band_sat_pos", 16'h7FFF);
        band_a[0] = 16'sh8000;
        directed("band_sat_neg", 16'h8000);
        band_a[0] = 16'sh7FFF;
        pot_a[1] = 12'hFFF; band_a[1] = 16'sh8000;
        directed("band_sat_cancel", 16'hFFFF);

        // Accumulator saturation
        set_all(12'hFFF, 16'h7FFF);
        directed("acc_sat_pos", 16'h7FFF);
        set_all(12'hFFF, 16'h8000);
        directed("acc_sat_neg", 16'h8000);

        // Stray strobe 3 cycles into a sample, then back-to-back accept
        rand_arrays();
        exp_a = model();
        capture();
        wait_result("overrun_mid", exp_a, 3);
        rand_arrays();
        exp_b = model();
        capture();
        wait_result("back_to_back", exp_b, 0);

        // Stray strobe during the DONE cycle must be dropped
        rand_arrays();
        exp_a = model();
        capture();
        wait_result("overrun_done", exp_a, LAT);
        held = mix_out;
        @(posedge clk);
        #1;
        chk("done_strobe_not_taken", {31'd0, busy}, 32'd0);
        chk("hold_mix_vld", {31'd0, mix_vld}, 32'd0);
        chk("hold_mix_out", {16'd0, mix_out}, {16'd0, held});

        // Reset in the 6th busy cycle aborts the sample
        rand_arrays();
        capture();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_mix_out", {16'd0, mix_out}, 32'd0);
        chk("midrst_busy",    {31'd0, busy},    32'd0);
        chk("midrst_mix_vld", {31'd0, mix_vld}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clk);
            #1;
            if (mix_vld || busy) stray = 1'b1;
        end
        chk("midrst_no_result", {31'd0, stray}, 32'd0);
        rand_arrays();
        directed("after_rst", model());

        // Randomised samples, some with extreme pots/bands mixed in
        for (int i = 0; i < 20; i++) begin
            rand_arrays();
            if (i % 4 == 1) pot_a[$urandom_range(0, NB-1)] = 12'hFFF;
            if (i % 4 == 2) band_a[$urandom_range(0, NB-1)] = 16'sh8000;
            if (i % 5 == 3) set_all(12'hFFF, 16'($urandom_range(0, 1) ? 16'h7FFF : 16'h8000));
            directed("random", model());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
